// File: rtl/bsg_flow_convert_credit.sv
// bsg_flow_convert_credit: per-channel ready/valid to valid/credit converter with saturating credit counters
module bsg_flow_convert_credit #(
   parameter int els_p         = 16,
   parameter int width_p       = 8,
   parameter int max_credits_p = 4,
   parameter int credit_lg_p   = 0,
   localparam int cw           = $clog2(max_credits_p + 1)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [els_p-1:0]         v_i,
   input  logic [els_p*width_p-1:0] data_i,
   output logic [els_p-1:0]         ready_o,
   output logic [els_p-1:0]         v_o,
   output logic [els_p*width_p-1:0] data_o,
   input  logic [els_p-1:0]         credit_i,
   output logic [els_p*cw-1:0]      credits_o,
   output logic [els_p-1:0]         overflow_o
);
   localparam logic [cw:0] step_lp = (cw+1)'(1 << credit_lg_p);
   localparam logic [cw:0] max_lp  = (cw+1)'(max_credits_p);

   assign data_o = data_i;

   always_ff @(posedge clk_i)
      assert (max_credits_p >= 1 && (1 << credit_lg_p) <= max_credits_p);

   for (genvar i = 0; i < els_p; i++) begin : ch
      logic [cw-1:0] cnt_q, cnt_d;
      logic [cw:0]   sum;
      logic          ovf, ovf_q;
      // one extra bit so a credit landing on a full counter is visible before saturation
      always_comb begin
         sum   = {1'b0, cnt_q} - (cw+1)'(v_o[i]) + (credit_i[i] ? step_lp : '0);
         ovf   = sum > max_lp;
         cnt_d = ovf ? max_lp[cw-1:0] : sum[cw-1:0];
      end
      always_ff @(posedge clk_i) begin
         if (!reset_n_i) begin
            cnt_q <= max_lp[cw-1:0];
            ovf_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_q | ovf;
         end
      end
      assign ready_o[i]               = reset_n_i & (cnt_q != '0);
      assign v_o[i]                   = v_i[i] & ready_o[i];
      assign credits_o[i*cw +: cw]    = cnt_q;
      assign overflow_o[i]            = ovf_q;
   end
endmodule

// File: tb/tb_bsg_flow_convert_credit.sv
// tb_bsg_flow_convert_credit: directed checks on two instances, one credit per pulse and two credits per pulse
module tb_bsg_flow_convert_credit;
   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [15:0]  v_in = '0, credit = '0;
   logic [127:0] din = '0;
   logic [15:0]  rdy0, vo0, ovf0, rdy1, vo1, ovf1;
   logic [127:0] dout0, dout1;
   logic [47:0]  cr0, cr1;
   int errs = 0, checks = 0;

   localparam logic [47:0] all4 = {16{3'd4}};

   always #5 clk = ~clk;

   bsg_flow_convert_credit #(.credit_lg_p(0)) d0 (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in), .data_i(din), .ready_o(rdy0),
      .v_o(vo0), .data_o(dout0), .credit_i(credit), .credits_o(cr0), .overflow_o(ovf0));

   bsg_flow_convert_credit #(.credit_lg_p(1)) d1 (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in), .data_i(din), .ready_o(rdy1),
      .v_o(vo1), .data_o(dout1), .credit_i(credit), .credits_o(cr1), .overflow_o(ovf1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] cf(input logic [47:0] v, input int c);
      return v[c*3 +: 3];
   endfunction

   initial begin
      v_in = '1;
      cyc();
      #1;
      chk("rst_ready", {rdy1, rdy0}, 32'h0);
      chk("rst_vo", {vo1, vo0}, 32'h0);
      cyc();
      reset_n = 1'b1;
      v_in = '0;
      #1;
      chk("idle_cr0", cr0, all4);
      chk("idle_cr1", cr1, all4);
      chk("idle_ready", rdy0, 16'hffff);
      chk("idle_vo", vo0, 16'h0);
      chk("idle_ovf", {ovf1, ovf0}, 32'h0);

      for (int k = 0; k < 6; k++) begin
         v_in[0] = 1'b1;
         din = {$urandom, $urandom, $urandom, $urandom};
         #1;
         chk($sformatf("drain_cr%0d", k), cf(cr0, 0), (k < 4) ? 3'(4 - k) : 3'd0);
         chk($sformatf("drain_rdy%0d", k), rdy0[0], k < 4);
         chk($sformatf("drain_vo%0d", k), vo0[0], k < 4);
         chk($sformatf("drain_data%0d", k), dout0, din);
         cyc();
      end
      chk("drain_others", cr0[47:3], all4[47:3]);
      chk("drain_ready_others", rdy0[15:1], 15'h7fff);

      credit[0] = 1'b1;
      #1;
      chk("refill_rdy_t", rdy0[0], 1'b0);
      cyc();
      credit[0] = 1'b0;
      #1;
      chk("refill_rdy_t1", rdy0[0], 1'b1);
      chk("refill_vo_t1", vo0[0], 1'b1);
      chk("refill_cr_t1", cf(cr0, 0), 3'd1);
      chk("refill_cr1_t1", cf(cr1, 0), 3'd2);
      cyc();
      v_in[0] = 1'b0;
      #1;
      chk("refill_cr_t2", cf(cr0, 0), 3'd0);
      chk("refill_rdy_t2", rdy0[0], 1'b0);
      chk("refill_cr1_t2", cf(cr1, 0), 3'd1);

      v_in[3] = 1'b1;
      cyc();
      cyc();
      credit[3] = 1'b1;
      #1;
      chk("simul_pre", cf(cr0, 3), 3'd2);
      cyc();
      v_in[3] = 1'b0;
      credit[3] = 1'b0;
      #1;
      chk("simul_lg0", cf(cr0, 3), 3'd2);
      chk("simul_lg1", cf(cr1, 3), 3'd3);
      chk("simul_noovf", {ovf1, ovf0}, 32'h0);

      credit[5] = 1'b1;
      cyc();
      credit[5] = 1'b0;
      #1;
      chk("ovf_cr0", cf(cr0, 5), 3'd4);
      chk("ovf_cr1", cf(cr1, 5), 3'd4);
      chk("ovf_flag0", ovf0, 16'h0020);
      chk("ovf_flag1", ovf1, 16'h0020);
      for (int k = 0; k < 10; k++) begin
         v_in[5] = 1'b1;
         credit[5] = k[0];
         cyc();
      end
      v_in[5] = 1'b0;
      credit[5] = 1'b0;
      #1;
      chk("ovf_sticky0", ovf0[5], 1'b1);
      chk("ovf_sticky1", ovf1[5], 1'b1);
      chk("ovf_traffic_cr0", cf(cr0, 5), 3'd1);
      chk("ovf_traffic_cr1", cf(cr1, 5), 3'd4);
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      #1;
      chk("ovf_cleared", {ovf1, ovf0}, 32'h0);
      chk("ovf_reset_cr0", cr0, all4);

      for (int k = 0; k < 8; k++) begin
         v_in = 16'($urandom);
         credit = 16'($urandom);
         din = {$urandom, $urandom, $urandom, $urandom};
         cyc();
      end
      reset_n = 1'b0;
      v_in = '1;
      credit = 16'($urandom) | 16'h0001;
      #1;
      chk("mid_vo", {vo1, vo0}, 32'h0);
      chk("mid_ready", {rdy1, rdy0}, 32'h0);
      cyc();
      reset_n = 1'b1;
      v_in = '0;
      credit = '0;
      #1;
      chk("mid_cr0", cr0, all4);
      chk("mid_cr1", cr1, all4);
      chk("mid_ovf", {ovf1, ovf0}, 32'h0);
      chk("mid_ready_after", rdy0, 16'hffff);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
